// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and constants for the Gray-code decoder
package gray_pkg;

    typedef enum logic {
        IDLE,
        TRACK
    } gray_dec_state_e;

    localparam logic DirUp   = 1'b1;
    localparam logic DirDown = 1'b0;

endpackage

// File: rtl/gray_decoder_if.sv
// rtl/gray_decoder_if.sv - input/output handshake bundle of the Gray-code decoder
interface gray_decoder_if #(
    parameter int Width = 4
);
    logic [Width-1:0] gray_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] binary_o;
    logic             valid_o;
    logic             ready_i;
    logic             dir_o;
    logic             step_err_o;

    modport slave (
        input  gray_i, valid_i, ready_i,
        output ready_o, binary_o, valid_o, dir_o, step_err_o
    );

    modport master (
        output gray_i, valid_i, ready_i,
        input  ready_o, binary_o, valid_o, dir_o, step_err_o
    );
endinterface

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter, inverse of bin2gray
module gray2bin #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] gray_i,
    output logic [Width-1:0] binary_o
);

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < Width; i++) begin : g_bit
        assign binary_o[i] = ^gray_i[Width-1:i];
    end

endmodule

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - registered Gray decoder with direction tracking and step-error counting
module gray_decoder
    import gray_pkg::*;
#(
    parameter int Width       = 4,
    parameter int ErrCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    gray_decoder_if.slave          io,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    gray_dec_state_e        state_q;
    logic [Width-1:0]       bin_d;
    logic [Width-1:0]       prev_q;
    logic [Width-1:0]       delta;
    logic [Width-1:0]       binary_q;
    logic                   valid_q;
    logic                   dir_q;
    logic                   step_err_q;
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic                   accept;
    logic                   transfer;

    gray2bin #(.Width(Width)) u_gray2bin (
        .gray_i   (io.gray_i),
        .binary_o (bin_d)
    );

    assign io.ready_o    = !valid_q || io.ready_i;
    assign accept        = io.valid_i && io.ready_o;
    assign transfer      = valid_q && io.ready_i;
    assign delta         = bin_d - prev_q;

    assign io.binary_o   = binary_q;
    assign io.valid_o    = valid_q;
    assign io.dir_o      = dir_q;
    assign io.step_err_o = step_err_q;
    assign err_cnt_o     = err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            binary_q   <= '0;
            valid_q    <= 1'b0;
            dir_q      <= DirDown;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (accept) begin
                valid_q  <= 1'b1;
                binary_q <= bin_d;
                prev_q   <= bin_d;
                state_q  <= TRACK;
                // A clear in the accept cycle makes this word the first of a fresh history.
                if (clear_i || state_q == IDLE) begin
                    dir_q      <= DirDown;
                    step_err_q <= 1'b0;
                end else if (delta == Width'(1)) begin
                    dir_q      <= DirUp;
                    step_err_q <= 1'b0;
                end else if (delta == '1) begin
                    dir_q      <= DirDown;
                    step_err_q <= 1'b0;
                end else if (delta == '0) begin
                    step_err_q <= 1'b0;
                end else begin
                    step_err_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
                    end
                end
            end else if (transfer) begin
                valid_q <= 1'b0;
            end

            if (clear_i) begin
                err_cnt_q <= '0;
                if (!accept) begin
                    state_q <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - self-checking bench for gray_decoder against a behavioural model
module tb_gray_decoder;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic [7:0] err_cnt8;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad   = 0;

    gray_decoder_if #(.Width(4)) u_if ();
    gray_decoder_if #(.Width(4)) u_if2 ();

    assign u_if2.gray_i  = u_if.gray_i;
    assign u_if2.valid_i = u_if.valid_i;
    assign u_if2.ready_i = u_if.ready_i;

    gray_decoder #(.Width(4), .ErrCntWidth(8)) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .io        (u_if.slave),
        .err_cnt_o (err_cnt8)
    );

    gray_decoder #(.Width(4), .ErrCntWidth(2)) u_dut_sat (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .io        (u_if2.slave),
        .err_cnt_o (err_cnt2)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: what the outputs should hold right now.
    bit       m_valid;
    int       m_bin;
    bit       m_dir;
    bit       m_err;
    int       m_cnt;
    bit       m_have_prev;
    int       m_prev;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int from_gray(input int g);
        int b;
        b = g;
        for (int s = 1; s < 4; s = s * 2) b = b ^ (b >> s);
        return b & 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_bin = 0; m_dir = 0; m_err = 0; m_cnt = 0;
        m_have_prev = 0; m_prev = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":valid_o"}, 32'(u_if.valid_o), 32'(m_valid));
        chk({tag, ":binary_o"}, 32'(u_if.binary_o), 32'(m_bin));
        chk({tag, ":dir_o"}, 32'(u_if.dir_o), 32'(m_dir));
        chk({tag, ":step_err_o"}, 32'(u_if.step_err_o), 32'(m_err));
        chk({tag, ":err_cnt8"}, 32'(err_cnt8), 32'((m_cnt > 255) ? 255 : m_cnt));
        chk({tag, ":err_cnt2"}, 32'(err_cnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // One clock cycle: drive at negedge, predict, sample at next negedge.
    task automatic step(input string tag, input int bin, input bit v, input bit rdy, input bit clr);
        bit acc;
        int b;
        int d;
        u_if.gray_i  = 4'(to_gray(bin));
        u_if.valid_i = v;
        u_if.ready_i = rdy;
        clear_i      = clr;
        #1;
        chk({tag, ":ready_o"}, 32'(u_if.ready_o), 32'(!m_valid || rdy));
        acc = v && (!m_valid || rdy);
        if (acc) begin
            b = from_gray(to_gray(bin));
            m_valid = 1;
            m_bin   = b;
            if (clr || !m_have_prev) begin
                m_dir = 0;
                m_err = 0;
            end else begin
                d = (b - m_prev + 16) % 16;
                m_err = 0;
                if (d == 1) m_dir = 1;
                else if (d == 15) m_dir = 0;
                else if (d != 0) begin
                    m_err = 1;
                    m_cnt++;
                end
            end
            m_prev = b;
            m_have_prev = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (clr) begin
            m_cnt = 0;
            if (!acc) m_have_prev = 0;
        end
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    int rb;
    int r;

    initial begin
        rst_ni = 1'b0;
        clear_i = 1'b0;
        u_if.gray_i = '0;
        u_if.valid_i = 1'b0;
        u_if.ready_i = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_outputs("reset");
        rst_ni = 1'b1;

        // Basic stream 0..3
        step("stream0", 0, 1, 1, 0);
        step("stream1", 1, 1, 1, 0);
        step("stream2", 2, 1, 1, 0);
        step("stream3", 3, 1, 1, 0);
        step("drain", 0, 0, 1, 0);

        // Wrap-around both ways
        step("wrap15", 15, 1, 1, 0);
        step("wrap0", 0, 1, 1, 0);
        step("wrap15b", 15, 1, 1, 0);

        // Illegal step then legal
        step("ill1", 1, 1, 1, 0);
        step("ill4", 4, 1, 1, 0);
        step("ill5", 5, 1, 1, 0);

        // Back-pressure after word 2
        step("bp2", 2, 1, 1, 0);
        step("bp_a", 3, 1, 0, 0);
        step("bp_b", 3, 1, 0, 0);
        step("bp_c", 3, 1, 0, 0);
        step("bp_go", 3, 1, 1, 0);
        step("bp_next", 4, 1, 1, 0);

        // Build err count then clear with accept
        step("e_a", 9, 1, 1, 0);
        step("e_b", 1, 1, 1, 0);
        step("e_c", 12, 1, 1, 0);
        step("clr8", 8, 1, 1, 1);
        step("clr9", 9, 1, 1, 0);

        // Clear without accept while output is stalled
        step("cs_a", 14, 1, 0, 0);
        step("cs_clr", 14, 0, 0, 1);
        step("cs_go", 13, 1, 1, 0);

        // Saturation: five illegal steps
        step("sat0", 0, 1, 1, 0);
        for (int i = 1; i <= 5; i++) step("sat", (i * 4) % 16, 1, 1, 0);

        // Reset while stalled
        step("rs_a", 7, 1, 0, 0);
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_mid:valid_o", 32'(u_if.valid_o), 32'(0));
        chk("rst_mid:err_cnt8", 32'(err_cnt8), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("rs_b", 6, 1, 1, 0);

        // Randomised stream
        rb = 6;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4) rb = (rb + 1) % 16;
            else if (r < 7) rb = (rb + 15) % 16;
            else if (r == 8) rb = $urandom_range(0, 15);
            step("rand", rb, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
Registered Gray-to-binary decoder with valid/ready handshake on input and output; it is the receive-side counterpart of the 4-bit binary-to-Gray encoder.
Tracks the last accepted code to report count direction and flag illegal Gray steps (more than one bit changed between consecutive codes).
Sits downstream of Gray-coded counters/position sources and feeds binary consumers.
Single clock domain.

Parameters:
Width, 4, code width in bits (>= 2)
ErrCntWidth, 8, width of saturating step-error counter

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
gray_i  input  Width  Gray-coded input word
valid_i  input  1  gray_i valid
ready_o  output  1  block can accept gray_i this cycle
clear_i  input  1  synchronous: forget tracking history, zero err_cnt_o
binary_o  output  Width  decoded binary value
valid_o  output  1  binary_o/dir_o/step_err_o valid
ready_i  input  1  downstream accepts output this cycle
dir_o  output  1  1 = counting up, 0 = down/unknown
step_err_o  output  1  this output word violated single-step rule
err_cnt_o  output  ErrCntWidth  saturating count of step errors

Behaviour:
- Reset (rst_ni low, async): valid_o=0, binary_o=0, dir_o=0, step_err_o=0, err_cnt_o=0, state=IDLE, prev_q=0.
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0. Purely combinational ahead of output register.
- Handshake: ready_o = !valid_o || ready_i. Accept = valid_i && ready_o. Output transfer = valid_o && ready_i.
- Latency: 1 cycle. Word accepted at edge N appears on outputs after edge N, valid_o=1.
- Full throughput: one word per cycle when ready_i held high.
- Back-pressure: while valid_o && !ready_i, binary_o, dir_o and step_err_o hold stable; ready_o=0.
- Drain: valid_o falls on a transfer cycle with no accept.
- FSM states:
  - IDLE: no history. Accept -> TRACK; output dir_o=0, step_err_o=0; prev_q <= b.
  - TRACK: on accept, compute d = (b - prev_q) mod 2^Width.
    - d=1: dir_o=1, no error.
    - d=all-ones: dir_o=0, no error.
    - d=0: repeat; dir_o unchanged, no error.
    - Otherwise: step_err_o=1, dir_o unchanged, err_cnt_o += 1 (saturating at all-ones).
    - prev_q <= b in every case, including errors.
- Wrap-around: max->0 (d=1) is up; 0->max is down; neither is an error.
- clear_i:
  - Next state IDLE; err_cnt_o <= 0.
  - Does not alter a word already held on the outputs.
  - Clear and accept in the same cycle: the accepted word is treated as IDLE/first (no error, dir 0), FSM ends in TRACK, err_cnt_o=0.
- Error counter: increments only on accept of an erroneous word, never on stall cycles.
- Reset mid-stall: output word is discarded; valid_o=0 immediately.

Decomposition:
- Package gray_pkg:
  - typedef enum logic {IDLE, TRACK} gray_dec_state_e
  - localparam DirUp=1'b1, DirDown=1'b0
- Sub-module gray2bin:
  - Combinational, parameter Width; ports gray_i, binary_o.
  - Reusable inverse of bin2gray.

Test Plan:
- Reset then stream gray 0000,0001,0011,0010 with ready_i=1 -> binary 0,1,2,3 one cycle after each accept; dir_o 0,1,1,1; step_err_o all 0.
- Wrap: feed 1000 (15) then 0000 (0) then 1000 (15) -> dir_o up then down; step_err_o=0; err_cnt_o=0.
- Illegal step: feed 0001 (1) then 0110 (4) -> step_err_o=1 on second word, err_cnt_o=1, dir_o unchanged; then 0111 (5) -> step_err_o=0, dir_o=1.
- Back-pressure: ready_i=0 for 3 cycles after word 0011 -> ready_o=0, binary_o=2 stable, valid_o=1; ready_i=1 -> transfer, next word accepted same cycle.
- Clear: err_cnt_o=3, assert clear_i with accept of 1100 (8) -> output step_err_o=0, dir_o=0, err_cnt_o=0; following 1101 (9) -> dir_o=1.
- Saturation: ErrCntWidth=2, inject 5 illegal steps -> err_cnt_o stops at 3.
